s3g_pkt_rx: RTL and testbench

S3G_PKT_RX -- requirements
Module: s3g_pkt_rx

---
 rtl/s3g_pkt_rx.sv | 197 +++++++++++++++++++
 tb/tb_s3g_pkt_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/s3g_pkt_rx.sv
// s3g_pkt_rx -- framed packet receiver with CRC-8 check and ping-pong payload buffer.
//
// Frame: 0xD5, length (1..MAX_LEN), payload bytes, CRC-8 (Maxim/1-Wire, over payload).
// A good frame is committed atomically: payload_len, regs_out and the read bank all switch
// in the cycle packet_done pulses. Failed frames leave committed data untouched.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   rx_data, rx_done    received byte and its one-cycle strobe
//   packet_done         one-cycle pulse on a good packet
//   packet_error        one-cycle pulse on a failed packet
//   err_code            last failure cause (0 none, 1 CRC, 2 length, 3 timeout)
//   busy                frame reception in progress
//   buffer_valid        a committed packet is readable
//   payload_len         length of the committed packet
//   regs_out            committed bytes 0..NREG-1, byte i at [8i+7:8i]
//   buffer_addr/data    committed payload read port, 1-cycle latency
//   good_cnt, bad_cnt   packet statistics
//
// Build option: define S3G_RX_STATS_EN to enable the saturating good/bad counters;
// otherwise both read constant 0.

module s3g_pkt_rx #(
   parameter int MAX_LEN     = 32,
   parameter int NREG        = 16,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_done,
   output logic              packet_done,
   output logic              packet_error,
   output logic [1:0]        err_code,
   output logic              busy,
   output logic              buffer_valid,
   output logic [7:0]        payload_len,
   output logic [NREG*8-1:0] regs_out,
   input  logic [7:0]        buffer_addr,
   output logic [7:0]        buffer_data,
   output logic [15:0]       good_cnt,
   output logic [15:0]       bad_cnt
);

   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [7:0]    MAX_LEN8 = 8'(MAX_LEN);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {S_INIT, S_LEN, S_DATA, S_CRC} state_t;

   state_t                 state;
   logic [7:0]             crc;
   logic [7:0]             byte_cnt;
   logic [7:0]             wptr;
   logic [7:0]             len_q;
   logic [TW-1:0]          tmr;
   logic                   bank_sel;   // committed (read) bank
   logic [NREG-1:0][7:0]   regs_q;
   logic [7:0]             mem [2][MAX_LEN];

   // timer will hit TIMEOUT_CYC on this edge; a byte arriving now takes priority
   logic tmo;
   assign tmo = (tmr == TMO_LAST) && !rx_done;

   assign busy     = (state != S_INIT);
   assign regs_out = regs_q;

   function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] x;
      x = c ^ d;
      for (int k = 0; k < 8; k++)
         x = x[0] ? ((x >> 1) ^ 8'h8C) : (x >> 1);
      return x;
   endfunction

   // staging writes always target the bank that is not currently committed
   always_ff @(posedge clk) begin
      if (rst && state == S_DATA && rx_done)
         mem[~bank_sel][wptr[AW-1:0]] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         buffer_data <= 8'h00;
      else if (buffer_addr < MAX_LEN8)
         buffer_data <= mem[bank_sel][buffer_addr[AW-1:0]];
      else
         buffer_data <= 8'h00;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= S_INIT;
         crc          <= 8'h00;
         byte_cnt     <= 8'h00;
         wptr         <= 8'h00;
         len_q        <= 8'h00;
         tmr          <= '0;
         bank_sel     <= 1'b0;
         packet_done  <= 1'b0;
         packet_error <= 1'b0;
         err_code     <= 2'd0;
         buffer_valid <= 1'b0;
         payload_len  <= 8'h00;
         regs_q       <= '0;
      end else begin
         packet_done  <= 1'b0;
         packet_error <= 1'b0;

         if (rx_done || state == S_INIT)
            tmr <= '0;
         else
            tmr <= tmr + 1'b1;

         case (state)
            S_INIT: begin
               if (rx_done && rx_data == 8'hD5)
                  state <= S_LEN;
            end
            S_LEN: begin
               if (rx_done) begin
                  if (rx_data == 8'h00 || rx_data > MAX_LEN8) begin
                     state        <= S_INIT;
                     packet_error <= 1'b1;
                     err_code     <= 2'd2;
                  end else begin
                     state    <= S_DATA;
                     byte_cnt <= rx_data;
                     len_q    <= rx_data;
                     crc      <= 8'h00;
                     wptr     <= 8'h00;
                  end
               end else if (tmo) begin
                  state        <= S_INIT;
                  packet_error <= 1'b1;
                  err_code     <= 2'd3;
               end
            end
            S_DATA: begin
               if (rx_done) begin
                  crc      <= crc_upd(crc, rx_data);
                  wptr     <= wptr + 8'd1;
                  byte_cnt <= byte_cnt - 8'd1;
                  if (byte_cnt == 8'd1)
                     state <= S_CRC;
               end else if (tmo) begin
                  state        <= S_INIT;
                  packet_error <= 1'b1;
                  err_code     <= 2'd3;
               end
            end
            S_CRC: begin
               if (rx_done) begin
                  state <= S_INIT;
                  if (rx_data == crc) begin
                     // commit: staging bank becomes the read bank
                     packet_done  <= 1'b1;
                     err_code     <= 2'd0;
                     buffer_valid <= 1'b1;
                     payload_len  <= len_q;
                     bank_sel     <= ~bank_sel;
                     for (int i = 0; i < NREG; i++)
                        regs_q[i] <= (8'(i) < len_q) ? mem[~bank_sel][AW'(i)] : 8'h00;
                  end else begin
                     packet_error <= 1'b1;
                     err_code     <= 2'd1;
                  end
               end else if (tmo) begin
                  state        <= S_INIT;
                  packet_error <= 1'b1;
                  err_code     <= 2'd3;
               end
            end
            default: state <= S_INIT;
         endcase
      end
   end

`ifdef S3G_RX_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         good_cnt <= 16'h0000;
         bad_cnt  <= 16'h0000;
      end else begin
         if (packet_done && good_cnt != 16'hFFFF)
            good_cnt <= good_cnt + 16'd1;
         if (packet_error && bad_cnt != 16'hFFFF)
            bad_cnt <= bad_cnt + 16'd1;
      end
   end
`else
   assign good_cnt = 16'h0000;
   assign bad_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_s3g_pkt_rx.sv
// Scoreboard bench for s3g_pkt_rx: stimulus pushes the expected outcome (pulse kind and
// committed state afterwards) for each frame; a negedge monitor pops and compares on
// every packet_done/packet_error pulse and flags any pulse nobody expected.

module tb_s3g_pkt_rx;

   localparam int MAX_LEN = 32;
   localparam int NREG    = 16;
   localparam int TMO     = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        rx_data;
   logic              rx_done;
   logic              packet_done, packet_error, busy, buffer_valid;
   logic [1:0]        err_code;
   logic [7:0]        payload_len, buffer_addr, buffer_data;
   logic [NREG*8-1:0] regs_out;
   logic [15:0]       good_cnt, bad_cnt;

   s3g_pkt_rx #(.MAX_LEN(MAX_LEN), .NREG(NREG), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
      .packet_done(packet_done), .packet_error(packet_error), .err_code(err_code),
      .busy(busy), .buffer_valid(buffer_valid), .payload_len(payload_len),
      .regs_out(regs_out), .buffer_addr(buffer_addr), .buffer_data(buffer_data),
      .good_cnt(good_cnt), .bad_cnt(bad_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       done;
      logic [1:0] code;
      logic [7:0] len;
      logic [7:0] b0;
      logic       valid;
   } exp_t;

   exp_t       q[$];
   exp_t       mon_e;
   int         vecs = 0;
   int         errs = 0;
   logic [7:0] m_len = 0, m_b0 = 0;
   logic       m_valid = 0;
   logic [1:0] m_code = 0;
   int         n_good = 0, n_bad = 0;
   logic [7:0] c;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] crc_step(input logic [7:0] cc, input logic [7:0] d);
      logic [7:0] x;
      x = cc ^ d;
      for (int k = 0; k < 8; k++)
         x = x[0] ? ((x >> 1) ^ 8'h8C) : (x >> 1);
      return x;
   endfunction

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_ok(input logic [7:0] len, input logic [7:0] b0);
      m_len = len; m_b0 = b0; m_valid = 1'b1; m_code = 2'd0; n_good++;
      q.push_back('{done: 1'b1, code: 2'd0, len: len, b0: b0, valid: 1'b1});
   endtask

   task automatic expect_err(input logic [1:0] code);
      m_code = code; n_bad++;
      q.push_back('{done: 1'b0, code: code, len: m_len, b0: m_b0, valid: m_valid});
   endtask

   // monitor
   always @(negedge clk) begin
      if (rst && (packet_done || packet_error)) begin
         if (q.size() == 0) begin
            vecs++; errs++;
            $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none", packet_done, packet_error);
         end else begin
            mon_e = q.pop_front();
            chk("pulse_kind", {packet_done, packet_error}, mon_e.done ? 2'b10 : 2'b01);
            chk("err_code", err_code, mon_e.code);
            chk("payload_len", payload_len, mon_e.len);
            chk("regs_byte0", regs_out[7:0], mon_e.b0);
            chk("buffer_valid", buffer_valid, mon_e.valid);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; rx_done = 1'b0; rx_data = 8'h00; buffer_addr = 8'h00;
      idle(3);
      chk("rst_done", packet_done, 0);
      chk("rst_error", packet_error, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", buffer_valid, 0);
      chk("rst_len", payload_len, 0);
      chk("rst_regs", regs_out, 0);
      chk("rst_code", err_code, 0);
      chk("rst_bdata", buffer_data, 0);
      chk("rst_good", good_cnt, 0);
      chk("rst_bad", bad_cnt, 0);
      rst = 1'b1;
      idle(2);

      // reset mid-payload: packet discarded, no pulse
      send(8'hD5);
      chk("busy_after_sync", busy, 1);
      send(8'h02); send(8'h11);
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      m_len = 0; m_b0 = 0; m_valid = 0; m_code = 0; n_good = 0; n_bad = 0;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", buffer_valid, 0);
      chk("midrst_len", payload_len, 0);
      chk("midrst_regs", regs_out, 0);
      chk("midrst_code", err_code, 0);
      chk("midrst_bdata", buffer_data, 0);
      idle(2);

      // good 1-byte packet, CRC(01)=5E
      expect_ok(8'd1, 8'h01);
      send(8'hD5); send(8'h01); send(8'h01); send(8'h5E);
      chk("busy_after_done", busy, 0);
      idle(2);
      chk("regs_upper_zero", regs_out[127:8], 0);
      buffer_addr = 8'd0;
      idle(1);
      chk("bdata_addr0", buffer_data, 8'h01);

      // CRC error keeps committed data
      expect_err(2'd1);
      send(8'hD5); send(8'h01); send(8'h02); send(8'h5E);
      idle(2);
      chk("bdata_after_crcerr", buffer_data, 8'h01);

      // length errors, then next sync is accepted
      expect_err(2'd2);
      send(8'hD5); send(8'h00);
      expect_err(2'd2);
      send(8'hD5); send(8'h21);
      c = crc_step(crc_step(8'h00, 8'h11), 8'h22);
      expect_ok(8'd2, 8'h11);
      send(8'hD5); send(8'h02); send(8'h11); send(8'h22); send(c);
      idle(2);
      chk("regs_byte1", regs_out[15:8], 8'h22);
      chk("regs_byte2", regs_out[23:16], 8'h00);
      buffer_addr = 8'd1;
      idle(1);
      chk("bdata_addr1", buffer_data, 8'h22);
      buffer_addr = 8'd40;
      idle(1);
      chk("bdata_oob", buffer_data, 8'h00);
      buffer_addr = 8'd0;

      // timeout fires 10 cycles after the AA strobe
      expect_err(2'd3);
      send(8'hD5); send(8'h03); send(8'hAA);
      for (int k = 1; k <= TMO; k++) begin
         @(negedge clk);
         if (k == TMO - 1) chk("tmo_not_early", packet_error, 0);
         if (k == TMO)     chk("tmo_on_time", packet_error, 1);
      end
      idle(3);
      chk("tmo_code_held", err_code, 2'd3);

      // strobe on the timeout cycle wins and reception continues
      c = crc_step(crc_step(crc_step(8'h00, 8'hAA), 8'hBB), 8'hCC);
      expect_ok(8'd3, 8'hAA);
      send(8'hD5); send(8'h03); send(8'hAA);
      idle(TMO - 2);
      send(8'hBB); send(8'hCC); send(c);
      idle(3);
      chk("busy_final", busy, 0);
      chk("regs_byte2_final", regs_out[23:16], 8'hCC);

`ifdef S3G_RX_STATS_EN
      chk("good_cnt", good_cnt, 16'(n_good));
      chk("bad_cnt", bad_cnt, 16'(n_bad));
`else
      chk("good_cnt", good_cnt, 16'd0);
      chk("bad_cnt", bad_cnt, 16'd0);
`endif
      chk("queue_drained", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
